apb_req_bridge: RTL and testbench

Bridge from the core-side request/grant data port to the peripheral APB bus. It accepts one request at a time (`req`/`gnt`/`rvalid` protocol) and runs it as a standard two-phase APB transfer (SETUP then ACCESS). It returns read data and error status on a single-cycle response strobe. It sits directly upstream of the APB peripheral interconnect (UART, GPIO, SPI, timer, event unit, I2C, FLL, SoC ctrl, debug, SPI accel, 7-seg, audio PWM), and rejects addresses outside the peripheral window before they reach the bus.

---
 rtl/apb_req_bridge.sv | 128 ++++++++++++
 tb/tb_apb_req_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_bridge.sv
// Request/grant data port to APB bridge: one transfer at a time, SETUP then ACCESS,
// with address-window rejection and an optional ACCESS-phase timeout.
module apb_req_bridge #(
    parameter int unsigned                 APB_ADDR_WIDTH = 32,
    parameter int unsigned                 APB_DATA_WIDTH = 32,
    parameter logic [APB_ADDR_WIDTH-1:0]   APB_BASE       = 32'h1A10_0000,
    parameter logic [APB_ADDR_WIDTH-1:0]   APB_END        = 32'h1A11_7FFF,
    parameter int unsigned                 TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    input  logic [APB_ADDR_WIDTH-1:0] data_addr_i,
    input  logic                      data_we_i,
    input  logic [APB_DATA_WIDTH-1:0] data_wdata_i,
    output logic                      data_rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] data_rdata_o,
    output logic                      data_err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    localparam int unsigned     CntW       = (TIMEOUT_CYCLES == 0) ? 1
                                                                   : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);
    localparam bit              TimeoutEn  = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                    state_q;
    logic [CntW-1:0]           cnt_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    logic                      pwrite_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      rvalid_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    logic                      err_q;

    logic in_range;
    logic timeout_hit;

    assign in_range    = (data_addr_i >= APB_BASE) && (data_addr_i <= APB_END);
    assign timeout_hit = TimeoutEn && (cnt_q == TimeoutVal);
    assign data_gnt_o  = data_req_i && (state_q == StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (data_req_i) begin
                        // Out-of-window requests never touch the bus outputs.
                        if (in_range) begin
                            paddr_q  <= data_addr_i;
                            pwdata_q <= data_wdata_i;
                            pwrite_q <= data_we_i;
                            psel_q   <= 1'b1;
                            state_q  <= StSetup;
                        end else begin
                            err_q    <= 1'b1;
                            rdata_q  <= '0;
                            rvalid_q <= 1'b1;
                            state_q  <= StResp;
                        end
                    end
                end
                StSetup: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= StAccess;
                end
                StAccess: begin
                    if (pready_i) begin
                        err_q     <= pslverr_i;
                        rdata_q   <= (pwrite_q || pslverr_i) ? '0 : prdata_i;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        state_q   <= StResp;
                    end else if (timeout_hit) begin
                        err_q     <= 1'b1;
                        rdata_q   <= '0;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        state_q   <= StResp;
                    end else if (cnt_q != {CntW{1'b1}}) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StResp: begin
                    rvalid_q <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pwrite_o      = pwrite_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Bench for apb_req_bridge: directed and random transfers against a latency/response model,
// with the bench acting as the APB slave.
module tb_apb_req_bridge;

    localparam int unsigned TO     = 4;
    localparam logic [31:0] BASE_A = 32'h1A10_0000;
    localparam logic [31:0] END_A  = 32'h1A11_7FFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_req_i;
    logic        data_gnt_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic [31:0] paddr_o;
    logic [31:0] pwdata_o;
    logic        pwrite_o;
    logic        psel_o;
    logic        penable_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;

    int n_cmp = 0;
    int n_err = 0;

    apb_req_bridge #(
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .APB_BASE       (BASE_A),
        .APB_END        (END_A),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_req_i    (data_req_i),
        .data_gnt_o    (data_gnt_o),
        .data_addr_i   (data_addr_i),
        .data_we_i     (data_we_i),
        .data_wdata_i  (data_wdata_i),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .paddr_o       (paddr_o),
        .pwdata_o      (pwdata_o),
        .pwrite_o      (pwrite_o),
        .psel_o        (psel_o),
        .penable_o     (penable_o),
        .prdata_i      (prdata_i),
        .pready_i      (pready_i),
        .pslverr_i     (pslverr_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One request; waits = ACCESS cycles the slave holds pready low before asserting it.
    // hold keeps req high while busy, to check that no grant is given until IDLE.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input int waits, input logic slverr, input logic [31:0] rd,
                           input bit hold, input string name);
        bit          in_rng;
        int          exp_lat, exp_acc, exp_psel;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          cyc, acc, psel_cnt, stab_bad, gnt_busy, lat;
        bit          got;
        logic        got_err;
        logic [31:0] got_rdata;

        in_rng = (addr >= BASE_A) && (addr <= END_A);
        if (!in_rng) begin
            exp_acc = 0; exp_lat = 1; exp_err = 1'b1; exp_rdata = '0;
        end else if (waits > int'(TO)) begin
            exp_acc = TO + 1; exp_lat = 2 + exp_acc; exp_err = 1'b1; exp_rdata = '0;
        end else begin
            exp_acc   = waits + 1;
            exp_lat   = 2 + exp_acc;
            exp_err   = slverr;
            exp_rdata = (we || slverr) ? 32'h0 : rd;
        end
        exp_psel = in_rng ? exp_acc + 1 : 0;

        @(negedge clk);
        n_cmp++;
        if (data_rvalid_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s rvalid_idle: got %b want 0", name, data_rvalid_o);
        end
        data_req_i   = 1'b1;
        data_addr_i  = addr;
        data_we_i    = we;
        data_wdata_i = wdata;
        pready_i     = 1'b0;
        pslverr_i    = 1'b0;
        prdata_i     = $urandom;
        #1;
        n_cmp++;
        if (data_gnt_o !== 1'b1) begin
            n_err++;
            $display("FAIL %s gnt: got %b want 1", name, data_gnt_o);
        end

        cyc = 0; got = 0; acc = 0; psel_cnt = 0; stab_bad = 0; gnt_busy = 0; lat = -1;
        got_err = 1'bx; got_rdata = 'x;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!hold) data_req_i = 1'b0;
            #1;
            if (hold && data_gnt_o) gnt_busy++;
            pready_i  = 1'b0;
            pslverr_i = 1'($urandom);
            prdata_i  = $urandom;
            if (psel_o) begin
                psel_cnt++;
                if (paddr_o !== addr || pwrite_o !== we || pwdata_o !== wdata) stab_bad++;
            end
            if (penable_o && !psel_o) stab_bad++;
            if (psel_o && penable_o) begin
                acc++;
                if (acc == waits + 1) begin
                    pready_i  = 1'b1;
                    pslverr_i = slverr;
                    prdata_i  = rd;
                end
            end
            if (data_rvalid_o) begin
                got       = 1;
                lat       = cyc;
                got_err   = data_err_o;
                got_rdata = data_rdata_o;
            end
        end
        pready_i = 1'b0;

        n_cmp++;
        if (!got || lat != exp_lat) begin
            n_err++;
            $display("FAIL %s rvalid_cycle: got %0d want %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (got_err !== exp_err) begin
            n_err++;
            $display("FAIL %s err: got %b want %b", name, got_err, exp_err);
        end
        n_cmp++;
        if (got_rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL %s rdata: got %h want %h", name, got_rdata, exp_rdata);
        end
        n_cmp++;
        if (acc != exp_acc) begin
            n_err++;
            $display("FAIL %s access_cycles: got %0d want %0d", name, acc, exp_acc);
        end
        n_cmp++;
        if (psel_cnt != exp_psel) begin
            n_err++;
            $display("FAIL %s psel_cycles: got %0d want %0d", name, psel_cnt, exp_psel);
        end
        n_cmp++;
        if (stab_bad != 0) begin
            n_err++;
            $display("FAIL %s apb_stability: got %0d bad cycles want 0", name, stab_bad);
        end
        if (hold) begin
            n_cmp++;
            if (gnt_busy != 0) begin
                n_err++;
                $display("FAIL %s gnt_while_busy: got %0d want 0", name, gnt_busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        data_req_i   = 1'b0;
        data_addr_i  = '0;
        data_we_i    = 1'b0;
        data_wdata_i = '0;
        prdata_i     = '0;
        pready_i     = 1'b0;
        pslverr_i    = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({data_rvalid_o, data_rdata_o, data_err_o, paddr_o, pwdata_o, pwrite_o, psel_o,
             penable_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rv=%b rd=%h err=%b pa=%h pw=%h wr=%b sel=%b en=%b want all 0",
                     data_rvalid_o, data_rdata_o, data_err_o, paddr_o, pwdata_o, pwrite_o,
                     psel_o, penable_o);
        end
        data_req_i = 1'b1;
        #1;
        n_cmp++;
        if (data_gnt_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_gnt_follows_req: got %b want 1", data_gnt_o);
        end
        data_req_i = 1'b0;
        #1;
        n_cmp++;
        if (data_gnt_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_gnt_low: got %b want 0", data_gnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_zero_wait();
        run_txn(32'h1A10_1000, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h5555_AAAA, 0, "write0");
    endtask

    task automatic test_read_wait3();
        run_txn(32'h1A10_3004, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678, 0, "read_wait3");
    endtask

    task automatic test_slverr();
        run_txn(32'h1A10_7000, 1'b0, 32'h0, 1, 1'b1, 32'hCAFE_F00D, 0, "read_slverr");
    endtask

    task automatic test_out_of_range();
        run_txn(32'h1A20_0000, 1'b0, 32'h0, 0, 1'b0, 32'h1111_1111, 0, "oor_high");
        run_txn(32'h1A0F_FFFC, 1'b0, 32'h0, 0, 1'b0, 32'h2222_2222, 0, "oor_low");
    endtask

    task automatic test_boundary();
        run_txn(BASE_A, 1'b0, 32'h0, 0, 1'b0, 32'hA5A5_0001, 0, "bound_lo");
        run_txn(END_A, 1'b0, 32'h0, 2, 1'b0, 32'hA5A5_0002, 0, "bound_hi");
    endtask

    task automatic test_timeout();
        run_txn(32'h1A10_4000, 1'b0, 32'h0, 20, 1'b0, 32'h3333_3333, 1, "timeout");
        run_txn(32'h1A10_4004, 1'b1, 32'h7777_0000, 0, 1'b0, 32'h0, 0, "after_timeout");
        run_txn(32'h1A10_4008, 1'b0, 32'h0, TO, 1'b0, 32'h4444_4444, 0, "timeout_race");
    endtask

    task automatic test_back_to_back();
        run_txn(32'h1A10_5000, 1'b1, 32'h0102_0304, 0, 1'b0, 32'h0, 1, "b2b_0");
        run_txn(32'h1A10_5004, 1'b0, 32'h0, 0, 1'b0, 32'h0BAD_CAFE, 1, "b2b_1");
        run_txn(32'h1A30_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1, "b2b_oor");
        run_txn(32'h1A10_5008, 1'b0, 32'h0, 1, 1'b0, 32'h600D_F00D, 0, "b2b_2");
    endtask

    task automatic test_reset_mid_access();
        int rv_seen;
        @(negedge clk);
        data_req_i  = 1'b1;
        data_addr_i = 32'h1A10_0010;
        data_we_i   = 1'b0;
        pready_i    = 1'b0;
        @(negedge clk);
        data_req_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (!(psel_o === 1'b1 && penable_o === 1'b1)) begin
            n_err++;
            $display("FAIL rst_mid in_access: got sel=%b en=%b want 1 1", psel_o, penable_o);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (psel_o !== 1'b0 || penable_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid async_drop: got sel=%b en=%b want 0 0", psel_o, penable_o);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        rv_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (data_rvalid_o || psel_o) rv_seen++;
        end
        n_cmp++;
        if (rv_seen != 0) begin
            n_err++;
            $display("FAIL rst_mid no_response: got %0d active cycles want 0", rv_seen);
        end
        run_txn(32'h1A10_0020, 1'b0, 32'h0, 0, 1'b0, 32'h8765_4321, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 5))
                0:       a = BASE_A - 32'h1 - ($urandom % 32'h0010_0000);
                1:       a = END_A + 32'h1 + ($urandom % 32'h0010_0000);
                2:       a = ($urandom_range(0, 1) == 0) ? BASE_A : END_A;
                default: a = BASE_A + ($urandom % 32'h0001_8000);
            endcase
            run_txn(a, 1'($urandom), $urandom, $urandom_range(0, 6),
                    ($urandom_range(0, 3) == 0), $urandom, 1'($urandom),
                    $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait3();
        test_slverr();
        test_out_of_range();
        test_boundary();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
